// File: rtl/autoapproach_pkg.sv
// autoapproach_pkg: shared widths and sequencer state encoding for the autoapproach blocks
package autoapproach_pkg;
  localparam int DAC_DATA_WID = 20;
  localparam int ADDR_WID = 13;
  localparam int RAM_WORDS = 2**ADDR_WID;
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, HOLD} seq_state_t;
endpackage

// File: rtl/waveform_sequencer_if.sv
// waveform_sequencer_if: host load port plus consumer word handshake
interface waveform_sequencer_if;
  import autoapproach_pkg::*;
  logic wr_en;
  logic [ADDR_WID-1:0] wr_addr;
  logic [DAC_DATA_WID-1:0] wr_data;
  logic wr_err;
  logic [ADDR_WID:0] wave_len;
  logic [DAC_DATA_WID-1:0] word;
  logic word_next;
  logic word_ok;
  logic word_last;
  logic word_rst;
  logic idle;
  modport master(
    output wr_en, wr_addr, wr_data, wave_len, word_next, word_rst,
    input wr_err, word, word_ok, word_last, idle
  );
  modport slave(
    input wr_en, wr_addr, wr_data, wave_len, word_next, word_rst,
    output wr_err, word, word_ok, word_last, idle
  );
endinterface

// File: rtl/waveform_bram.sv
// waveform_bram: simple dual-port read-first block RAM holding the waveform
module waveform_bram #(
  parameter int DW = 20,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end
endmodule

// File: rtl/waveform_sequencer.sv
// waveform_sequencer: serves the stored approach waveform one word per consumer request
module waveform_sequencer
  import autoapproach_pkg::*;
(
  input logic clk,
  input logic rst_n,
  waveform_sequencer_if.slave bus
);
  localparam logic [ADDR_WID:0] MAX_LEN = (ADDR_WID+1)'(RAM_WORDS);
  seq_state_t state, state_n;
  logic [ADDR_WID-1:0] ptr, ptr_n;
  logic [DAC_DATA_WID-1:0] word, word_n, ram_q;
  logic ok, ok_n, last, last_n, err;
  logic [ADDR_WID:0] len;
  logic idle, start;
  assign len = bus.wave_len > MAX_LEN ? MAX_LEN : bus.wave_len;
  assign idle = state == IDLE && ptr == '0;
  assign start = state == IDLE && bus.word_next && !bus.word_rst;
  // The BRAM address register is loaded on the request edge itself, so a
  // host write on that same edge is seen read-first (old data returned).
  waveform_bram #(.DW(DAC_DATA_WID), .AW(ADDR_WID)) u_bram (
    .clk(clk),
    .we(bus.wr_en && idle),
    .wa(bus.wr_addr),
    .wd(bus.wr_data),
    .re(start && len != '0),
    .ra(ptr),
    .q(ram_q)
  );
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    word_n = word;
    ok_n = ok;
    last_n = last;
    if (bus.word_rst) begin
      state_n = IDLE;
      ptr_n = '0;
      ok_n = 1'b0;
      last_n = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = bus.word_next ? FETCH : IDLE;
        FETCH: state_n = PRESENT;
        PRESENT: begin
          word_n = len == '0 ? '0 : ram_q;
          last_n = len == '0 || {1'b0, ptr} == len - 1'b1;
          ok_n = 1'b1;
          state_n = HOLD;
        end
        HOLD: begin
          if (!bus.word_next) begin
            ok_n = 1'b0;
            ptr_n = last ? '0 : ptr + 1'b1;
            state_n = IDLE;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      word <= '0;
      ok <= 1'b0;
      last <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      word <= word_n;
      ok <= ok_n;
      last <= last_n;
      err <= bus.wr_en && !idle;
    end
  end
  assign bus.word = word;
  assign bus.word_ok = ok;
  assign bus.word_last = last;
  assign bus.wr_err = err;
  assign bus.idle = idle;
endmodule

// File: tb/tb_waveform_sequencer.sv
// tb_waveform_sequencer: scoreboard bench with a queue-based reference model of the sequencer
module tb_waveform_sequencer;
  typedef struct {
    logic [19:0] w;
    logic        l;
  } exp_t;
  logic clk, rst_n;
  int total = 0, bad = 0;
  int mptr = 0, mlen = 0;
  logic [19:0] mmem [8192];
  exp_t sbq[$];
  logic prev_ok = 1'b0;
  waveform_sequencer_if bus();
  waveform_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.word_ok && !prev_ok) begin
      if (sbq.size() == 0) begin
        chk("unexpected_word", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("word", 32'(bus.word), 32'(e.w));
        chk("word_last", 32'(bus.word_last), 32'(e.l));
      end
    end
    prev_ok = bus.word_ok;
  end
  function automatic exp_t expect_now();
    exp_t e;
    e.w = mlen == 0 ? 20'h0 : mmem[mptr];
    e.l = mlen == 0 || mptr == mlen - 1;
    return e;
  endfunction
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_len(input int n);
    mlen = n > 8192 ? 8192 : n;
    bus.wave_len = 14'(n);
  endtask
  task automatic write(input int a, input logic [19:0] d);
    bit acc;
    acc = mptr == 0;
    bus.wr_en = 1'b1;
    bus.wr_addr = a[12:0];
    bus.wr_data = d;
    cyc();
    bus.wr_en = 1'b0;
    chk("wr_err", 32'(bus.wr_err), 32'(!acc));
    if (acc) mmem[a] = d;
    cyc();
    chk("wr_err_pulse", 32'(bus.wr_err), 32'd0);
  endtask
  task automatic rewind();
    bus.word_rst = 1'b1;
    cyc();
    bus.word_rst = 1'b0;
    mptr = 0;
    chk("rewind_ok", 32'(bus.word_ok), 32'd0);
    chk("rewind_idle", 32'(bus.idle), 32'd1);
  endtask
  task automatic request(input int hold, input bit wr = 1'b0, input int wa = 0, input logic [19:0] wd = 20'h0);
    exp_t e;
    int n;
    bit acc;
    e = expect_now();
    sbq.push_back(e);
    acc = mptr == 0;
    if (wr) begin
      bus.wr_en = 1'b1;
      bus.wr_addr = wa[12:0];
      bus.wr_data = wd;
    end
    bus.word_next = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
      if (n == 1 && wr) begin
        bus.wr_en = 1'b0;
        chk("req_wr_err", 32'(bus.wr_err), 32'(!acc));
        if (acc) mmem[wa] = wd;
      end
    end while (!bus.word_ok && n < 8);
    chk("latency", n, 3);
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk("hold_ok", 32'(bus.word_ok), 32'd1);
      chk("hold_word", 32'(bus.word), 32'(e.w));
      chk("hold_last", 32'(bus.word_last), 32'(e.l));
    end
    bus.word_next = 1'b0;
    cyc();
    chk("drop_ok", 32'(bus.word_ok), 32'd0);
    mptr = e.l ? 0 : mptr + 1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    int n;
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.word_next = 1'b0;
    bus.word_rst = 1'b0;
    set_len(0);
    repeat (3) @(negedge clk);
    chk("reset_word", 32'(bus.word), 32'd0);
    chk("reset_ok", 32'(bus.word_ok), 32'd0);
    chk("reset_last", 32'(bus.word_last), 32'd0);
    chk("reset_err", 32'(bus.wr_err), 32'd0);
    chk("reset_idle", 32'(bus.idle), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    set_len(3);
    write(0, 20'h00001);
    write(1, 20'h00002);
    write(2, 20'h00003);
    repeat (4) request(0);
    request(10);
    rewind();
    request(0);
    request(0);
    rewind();
    request(0);
    // Hold a word, try a host write (must be rejected), then rewind with the request still high.
    rewind();
    e = expect_now();
    sbq.push_back(e);
    bus.word_next = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!bus.word_ok && n < 8);
    chk("hold_latency", n, 3);
    bus.wr_en = 1'b1;
    bus.wr_addr = 13'd0;
    bus.wr_data = 20'hFFFFF;
    cyc();
    bus.wr_en = 1'b0;
    chk("hold_wr_err", 32'(bus.wr_err), 32'd1);
    chk("hold_wr_ok", 32'(bus.word_ok), 32'd1);
    bus.word_rst = 1'b1;
    cyc();
    chk("hold_rst_ok", 32'(bus.word_ok), 32'd0);
    chk("hold_rst_idle", 32'(bus.idle), 32'd1);
    chk("hold_err_pulse", 32'(bus.wr_err), 32'd0);
    repeat (3) begin
      cyc();
      chk("rst_held_ok", 32'(bus.word_ok), 32'd0);
      chk("rst_held_idle", 32'(bus.idle), 32'd1);
    end
    bus.word_rst = 1'b0;
    bus.word_next = 1'b0;
    mptr = 0;
    cyc();
    request(0);
    rewind();
    request(0, 1'b1, 0, 20'h00AAA);
    rewind();
    request(0);
    rewind();
    set_len(0);
    request(0);
    request(2);
    for (int k = 0; k < 60; k++) begin
      int act;
      act = $urandom_range(0, 11);
      if (act <= 5) request($urandom_range(0, 2));
      else if (act == 6) request(0, 1'b1, $urandom_range(0, 7), 20'($urandom));
      else if (act == 7) rewind();
      else if (act == 8) write($urandom_range(0, 7), 20'($urandom));
      else if (act == 9) begin
        rewind();
        set_len($urandom_range(0, 6));
        for (int i = 0; i < mlen; i++) write(i, 20'($urandom));
      end else request(1);
    end
    // Asynchronous reset mid-FETCH: outputs clear at once, BRAM keeps its data.
    rewind();
    set_len(3);
    write(0, 20'h00011);
    write(1, 20'h00022);
    write(2, 20'h00033);
    request(0);
    bus.word_next = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_word", 32'(bus.word), 32'd0);
    chk("async_ok", 32'(bus.word_ok), 32'd0);
    chk("async_last", 32'(bus.word_last), 32'd0);
    chk("async_err", 32'(bus.wr_err), 32'd0);
    chk("async_idle", 32'(bus.idle), 32'd1);
    bus.word_next = 1'b0;
    mptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    request(0);
    request(0);
    request(0);
    repeat (2) cyc();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/waveform_sequencer.md
Name: waveform_sequencer

Overview:
- Upstream stage of the autoapproach controller: owns the Block RAM holding the approach waveform and serves it one word per request.
- Host (CPU/Wishbone side) loads up to RAM_WORDS samples plus a length; the consumer pulls words through the word_next/word_ok handshake and receives word_last on the final sample.
- Words are served in order; the sequence wraps to index 0 after the last word.
- The consumer can rewind the sequence at any time with word_rst.

Parameters:
- DAC_DATA_WID, 20, width of one waveform sample (DAC data field).
- ADDR_WID, 13, BRAM address width.
- RAM_WORDS, 2**ADDR_WID, BRAM depth.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  host write strobe, single-cycle
- wr_addr  in  ADDR_WID  host write address
- wr_data  in  DAC_DATA_WID  host write sample
- wr_err  out  1  one-cycle pulse: write rejected (sequence in progress)
- wave_len  in  ADDR_WID+1  number of valid samples, 0..RAM_WORDS; must be held stable while a sequence runs
- word  out  DAC_DATA_WID  current sample
- word_next  in  1  consumer request level
- word_ok  out  1  word/word_last valid
- word_last  out  1  current word is index wave_len-1
- word_rst  in  1  rewind sequence to index 0
- idle  out  1  high in IDLE with ptr==0 (host may load)

Behaviour:
- Reset (rst_n low, async): state=IDLE, ptr=0, word=0, word_ok=0, word_last=0, wr_err=0. BRAM contents are not cleared.
- BRAM: one write port (host), one synchronous read port; read data is valid one cycle after the address is registered.
- States:
  - IDLE: word_ok=0. If word_next=1 at an edge, register rd_addr=ptr and go to FETCH.
  - FETCH: wait one cycle for BRAM data, then go to PRESENT.
  - PRESENT: latch word=ram_q and word_last=(ptr==wave_len-1); word_ok=1. Go to HOLD.
  - HOLD: hold word_ok, word and word_last while word_next=1. On word_next=0: word_ok<=0, ptr<=(word_last ? 0 : ptr+1), go to IDLE.
- Latency: word_ok rises 3 edges after the first edge sampling word_next=1. A consumer that drops word_next in the same cycle it sees word_ok gets exactly one word per request.
- wave_len==0: no BRAM read; PRESENT outputs word=0, word_last=1; ptr stays 0.
- word_rst (synchronous, highest priority over everything but rst_n): ptr<=0, state<=IDLE, word_ok<=0, word_last<=0.
  - word_rst held high continuously keeps the block in IDLE; requests are ignored.
  - word_rst and word_next high together: rewind wins; no fetch starts.
- Host writes:
  - Accepted only when idle=1: the BRAM is written the same edge.
  - Otherwise the write is dropped and wr_err pulses for one cycle.
  - A write and a word_next sampled on the same edge while idle: the write is accepted and the fetch starts. A read of the same address returns the old data (read-first).
- ptr width is ADDR_WID. wave_len values above RAM_WORDS are clamped to RAM_WORDS.
- word_next deasserted during FETCH: the transaction still completes. word_ok pulses for one cycle in PRESENT/HOLD, then the pointer advances.

Decomposition:
- Shared package (autoapproach_pkg): DAC_DATA_WID, ADDR_WID, and the state encoding constants (IDLE, FETCH, PRESENT, HOLD).
- Sub-module waveform_bram: simple dual-port RAM (one write port, one synchronous read port, read-first), inferred as Block RAM.
- Top level: sequencer FSM, pointer, and host-write gating.

Test Plan:
- Load [0x00001, 0x00002, 0x00003], wave_len=3; three request cycles -> words 1, 2, 3; word_last=0, 0, 1; word_ok rises 3 edges after each request.
- Continue with a fourth request -> word=0x00001, word_last=0 (wrap-around).
- Hold word_next=1 for 10 cycles after word_ok -> word/word_ok stable, ptr unchanged; drop word_next -> word_ok=0 next edge.
- Rewind and idle checks:
  - After 2 of 3 words, assert word_rst -> idle=1; the next request returns 0x00001.
  - Assert word_rst during HOLD -> word_ok=0 next edge.
- While in HOLD, wr_en with wr_addr=0, wr_data=0xFFFFF -> wr_err pulses 1 cycle; BRAM[0] is still 0x00001 on rewind and reread.
- wave_len=0 request -> word=0, word_last=1.
- rst_n low mid-FETCH -> all outputs 0 asynchronously, ptr=0; BRAM data survives.
